dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Parametrised data memory for the dCPU datapath, replacing the fixed 8x256 single-port array. Adds a valid/ready request port, per-byte write enables, a configurable pipelined read latency and a post-reset clear sequence. It sits between the core load/store stage and the storage array. Write select stays active-low, as on the existing data memory.

Parameters:
- DATA_W, 8: word width in bits; must be a multiple of 8. BE_W = DATA_W/8 is derived.
- ADDR_W, 8: address width. DEPTH = 2**ADDR_W words is derived.
- RD_LAT, 1: read latency in cycles, legal range 1..3. Any other value is an elaboration error.
- INIT_CLEAR, 1: 1 means zero-fill the memory after reset; 0 means skip the fill.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_wr_n  in  1  0 selects write, 1 selects read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte-lane write enables; bit i covers bits [8i+7:8i].
- err_inject  in  1  parity-corruption test input; used only with the optional feature.
- rsp_valid  out  1  read data valid; one-cycle pulse per accepted read.
- rsp_rdata  out  DATA_W  read data.
- rsp_perr  out  1  parity error flag, qualified by rsp_valid.
- init_done  out  1  clear sequence finished.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_perr=0, init_done=0. All read-pipeline valid bits are cleared and the FSM goes to INIT (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
- Reset asserted mid-operation discards in-flight reads (no rsp_valid) and restarts INIT. Writes already committed to the array are not rolled back; INIT then overwrites them.
- FSM states: INIT, RUN.
  - INIT: clear counter starts at 0. Writes 0 to word[cnt] with all lanes enabled, one word per cycle, for cycles 0..DEPTH-1. When cnt==DEPTH-1 the FSM moves to RUN. The counter is ADDR_W+1 bits wide, with no wrap.
  - INIT_CLEAR=0: the FSM enters RUN on the first cycle after reset release. Memory contents are then undefined.
  - RUN: init_done=1 and req_ready=1 every cycle. There is no stall source in RUN.
- A request is accepted on a cycle where req_valid and req_ready are both 1. Requests presented while req_ready=0 are ignored, not queued.
- Accepted write (req_wr_n=0):
  - Each lane i with req_be[i]=1 is updated at that clock edge; other lanes keep their value.
  - req_be all zero is accepted with no state change.
  - No response is generated.
- Accepted read (req_wr_n=1):
  - The array is sampled at the acceptance edge and reflects all writes accepted earlier.
  - rsp_valid pulses exactly RD_LAT cycles after acceptance (RD_LAT=1 means the next cycle), together with rsp_rdata.
  - Back-to-back reads are fully pipelined, one response per cycle, in order.
  - There is no response backpressure; the consumer must sink every response.
- Write followed by a read of the same address on the next cycle returns the new data. Single port means no same-cycle read/write collision.
- rsp_rdata holds its last value while rsp_valid=0.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - The array stores one even-parity bit per byte lane, written with that lane's data. INIT writes parity 0.
  - An accepted write with err_inject=1 stores the inverted parity for every enabled lane.
  - On a read, rsp_perr=1 with rsp_valid if any lane's stored parity mismatches its data. Parity is checked in the same pipeline stage as the data.
- Undefined: no parity storage, err_inject is ignored, and rsp_perr is tied 0.

Decomposition:
- Package dmem_pkg holds:
  - WR_N_WRITE=1'b0 and WR_N_READ=1'b1 constants;
  - the FSM state typedef (INIT, RUN);
  - RD_LAT_MIN=1 and RD_LAT_MAX=3;
  - a byte-parity function.
- One sub-module, dmem_array, holds storage only: per-lane write enable (plus parity bits under the macro) and an asynchronous read. dmem_ctrl owns the FSM, clear counter and read pipeline.

Test Plan:
- Reset release, INIT_CLEAR=1, ADDR_W=4 -> req_ready=0 and init_done=0 for exactly 16 cycles, then both 1. Reading every address returns 0.
- DATA_W=32, RD_LAT=2: write 0xAABBCCDD to addr 5 with be=0xF, then write 0x11223344 with be=0x5 -> read of addr 5 returns 0xAA22CC44, with rsp_valid exactly 2 cycles after acceptance.
- RD_LAT=3: back-to-back reads of addrs 1,2,3 (values 0x10,0x20,0x30) -> three consecutive rsp_valid cycles, in order, starting 3 cycles after the first acceptance.
- Write 0x5A to addr 7, then read addr 7 the next cycle -> 0x5A. A write with be=0 to addr 7 leaves a later read at 0x5A.
- Reset asserted one cycle after a read is accepted (RD_LAT=2) -> no rsp_valid; INIT restarts; old data at that address reads 0 afterwards.
- DMEM_PARITY_EN: write 0x0F with err_inject=1 to addr 3 -> read gives rsp_perr=1 and rdata 0x0F. A normal write then read gives rsp_perr=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared constants, FSM state type and parity helper for the
// dmem_ctrl data memory.
// Optional feature macro: DMEM_PARITY_EN (per-byte even parity storage/check).
package dmem_pkg;

    // Encoding of the active-low write select on the request port.
    localparam logic WR_N_WRITE = 1'b0;
    localparam logic WR_N_READ  = 1'b1;

    // Legal read-latency range.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } dmem_state_e;

    // Even parity bit for one byte: data plus parity has an even number of ones.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- storage for dmem_ctrl: 2**ADDR_W words of DATA_W bits with
// per-byte-lane write enables and an asynchronous (combinational) read.
// Optional feature macro: DMEM_PARITY_EN adds one stored parity bit per lane.
// Ports:
//   clk_i    clock, writes on rising edge
//   we_i     per-lane write enables
//   addr_i   shared read/write word address (single port)
//   wdata_i  write data
//   rdata_o  read data of word addr_i
//   wpar_i   per-lane parity bits to store   (DMEM_PARITY_EN only)
//   rpar_o   stored parity bits of word addr_i (DMEM_PARITY_EN only)
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic [BE_W-1:0]   we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
`ifdef DMEM_PARITY_EN
    ,
    input  logic [BE_W-1:0]   wpar_i,
    output logic [BE_W-1:0]   rpar_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage has no reset; contents are defined only by writes (or the
    // controller's clear sequence).
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];

`ifdef DMEM_PARITY_EN
    logic [BE_W-1:0] par_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < BE_W; i++) begin
            if (we_i[i]) par_q[addr_i][i] <= wpar_i[i];
        end
    end

    assign rpar_o = par_q[addr_i];
`endif

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- parametrised data memory controller: valid/ready request port,
// per-byte write enables, pipelined read of RD_LAT cycles and an optional
// zero-fill of the whole array after reset.
// Optional feature macro: DMEM_PARITY_EN (per-lane parity, err_inject, rsp_perr).
// Ports:
//   clk, rst_n           clock / synchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in RUN)
//   req_wr_n             0 = write, 1 = read
//   req_addr, req_wdata  word address / write data
//   req_be               byte-lane write enables
//   err_inject           store inverted parity on writes (parity build only)
//   rsp_valid            one-cycle pulse per accepted read, RD_LAT after accept
//   rsp_rdata            read data, held while rsp_valid=0
//   rsp_perr             parity error, qualified by rsp_valid
//   init_done            clear sequence finished (FSM in RUN)
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter  int DATA_W     = 8,
    parameter  int ADDR_W     = 8,
    parameter  int RD_LAT     = 1,
    parameter  int INIT_CLEAR = 1,
    localparam int BE_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr_n,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    input  logic              err_inject,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic              init_done
);

    localparam int             DEPTH    = 2 ** ADDR_W;
    localparam int             PW       = DATA_W + 1;  // {perr, data}
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("dmem_ctrl: RD_LAT must be in 1..3");
    end
    if (DATA_W <= 0 || DATA_W % 8 != 0) begin : g_bad_data_w
        $error("dmem_ctrl: DATA_W must be a positive multiple of 8");
    end

    // ---------------- FSM and clear counter ----------------
    dmem_state_e     state_q, state_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic            clr_we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (INIT_CLEAR != 0) ? INIT : RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            INIT: begin
                // Clear writes are suppressed while reset is held so the
                // sweep always starts cleanly from word 0 on release.
                clr_we = rst_n;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = RUN;
            end
            default: state_d = state_q;
        endcase
    end

    // Ready is masked by rst_n so a reset cycle never accepts a request,
    // including with INIT_CLEAR=0 where reset lands directly in RUN.
    assign req_ready = (state_q == RUN) && rst_n;
    assign init_done = req_ready;

    logic acc, wr_acc, rd_acc;
    assign acc    = req_valid && req_ready;
    assign wr_acc = acc && (req_wr_n == WR_N_WRITE);
    assign rd_acc = acc && (req_wr_n == WR_N_READ);

    // ---------------- array port mux ----------------
    logic [BE_W-1:0]   arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;
    logic              rd_perr;

    assign arr_we    = clr_we ? '1 : (wr_acc ? req_be : '0);
    assign arr_addr  = (state_q == INIT) ? cnt_q[ADDR_W-1:0] : req_addr;
    assign arr_wdata = clr_we ? '0 : req_wdata;

`ifdef DMEM_PARITY_EN
    logic [BE_W-1:0] arr_wpar, arr_rpar, rd_par;

    always_comb begin
        arr_wpar = '0;
        rd_par   = '0;
        for (int i = 0; i < BE_W; i++) begin
            arr_wpar[i] = clr_we ? 1'b0 : (byte_par(req_wdata[8*i +: 8]) ^ err_inject);
            rd_par[i]   = byte_par(arr_rdata[8*i +: 8]);
        end
    end
    assign rd_perr = |(arr_rpar ^ rd_par);

    dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BE_W(BE_W)) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata),
        .wpar_i  (arr_wpar),
        .rpar_o  (arr_rpar)
    );
`else
    logic unused_err_inject;
    assign unused_err_inject = err_inject;
    assign rd_perr           = 1'b0;

    dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BE_W(BE_W)) u_array (
        .clk_i   (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );
`endif

    // ---------------- read pipeline ----------------
    // Stage 0 captures the array at the acceptance edge; the last stage is the
    // output register. Each stage only loads when its input is valid, which
    // makes the output hold its value between responses.
    logic [RD_LAT-1:0]         vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][PW-1:0] dat_pipe_q, dat_pipe_d;

    always_comb begin
        vld_pipe_d    = '0;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[0] = rd_acc;
        if (rd_acc) dat_pipe_d[0] = {rd_perr, arr_rdata};
        for (int k = 1; k < RD_LAT; k++) begin
            vld_pipe_d[k] = vld_pipe_q[k-1];
            if (vld_pipe_q[k-1]) dat_pipe_d[k] = dat_pipe_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            dat_pipe_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            dat_pipe_q <= dat_pipe_d;
        end
    end

    assign rsp_valid = vld_pipe_q[RD_LAT-1];
    assign rsp_rdata = dat_pipe_q[RD_LAT-1][DATA_W-1:0];
    assign rsp_perr  = rsp_valid && dat_pipe_q[RD_LAT-1][DATA_W];

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl -- self-checking bench for dmem_ctrl (DATA_W=32, ADDR_W=4,
// RD_LAT=2, INIT_CLEAR=1). A word/lane-level reference model predicts every
// output each cycle; directed sequences cover the clear sweep, byte merge,
// pipelined reads, zero byte-enable, mid-read reset and parity injection,
// followed by randomized traffic with occasional resets.
module tb_dmem_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int RDL   = 2;
    localparam int BEW   = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic           req_wr_n;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic [BEW-1:0] req_be;
    logic           err_inject;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic           rsp_perr;
    logic           init_done;

    always #5 clk = ~clk;

    dmem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RDL), .INIT_CLEAR(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr_n   (req_wr_n),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .err_inject (err_inject),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_perr   (rsp_perr),
        .init_done  (init_done)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          perr;
    } rsp_t;

    logic [DW-1:0]  mdl_mem [DEPTH];
    logic [BEW-1:0] mdl_bad [DEPTH];   // lanes holding corrupted parity
    rsp_t           rq[$];
    int             cyc       = 0;
    int             init_left = DEPTH;
    logic [DW-1:0]  last_rdata = '0;
    int             checks    = 0;
    int             failures  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Apply the effect of one rising edge to the model, from the inputs the
    // DUT sees at that edge.
    task automatic model_edge();
        rsp_t r;
        if (!rst_n) begin
            init_left  = DEPTH;
            last_rdata = '0;
            rq.delete();
            for (int a = 0; a < DEPTH; a++) begin
                mdl_mem[a] = '0;
                mdl_bad[a] = '0;
            end
        end else if (init_left == 0) begin
            if (req_valid && !req_wr_n) begin
                for (int l = 0; l < BEW; l++) begin
                    if (req_be[l]) begin
                        mdl_mem[req_addr][8*l +: 8] = req_wdata[8*l +: 8];
`ifdef DMEM_PARITY_EN
                        mdl_bad[req_addr][l] = err_inject;
`else
                        mdl_bad[req_addr][l] = 1'b0;
`endif
                    end
                end
            end else if (req_valid && req_wr_n) begin
                r.due  = cyc + RDL;
                r.data = mdl_mem[req_addr];
                r.perr = |mdl_bad[req_addr];
                rq.push_back(r);
            end
        end else begin
            init_left--;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        logic exp_v, exp_rdy;
        rsp_t r;
        exp_rdy = rst_n && (init_left == 0);
        exp_v   = (rq.size() > 0) && (rq[0].due == cyc);
        chk("req_ready", req_ready, exp_rdy);
        chk("init_done", init_done, exp_rdy);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
            r          = rq.pop_front();
            last_rdata = r.data;
            chk("rsp_perr", rsp_perr, r.perr);
        end else begin
            chk("rsp_perr_idle", rsp_perr, 1'b0);
        end
        chk("rsp_rdata", rsp_rdata, last_rdata);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic issue(input logic wr_n, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BEW-1:0] be,
                         input logic inj);
        req_valid  = 1'b1;
        req_wr_n   = wr_n;
        req_addr   = addr;
        req_wdata  = data;
        req_be     = be;
        err_inject = inj;
        step();
        req_valid  = 1'b0;
        err_inject = 1'b0;
    endtask

    // Read with explicit latency and data/perr checks against constants.
    task automatic rd_expect(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                             input logic eperr, input string tag);
        issue(1'b1, addr, '0, '0, 1'b0);
        for (int k = 1; k < RDL; k++) begin
            chk({tag, "_early"}, rsp_valid, 1'b0);
            step();
        end
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_rdata, exp);
        chk({tag, "_perr"}, rsp_perr, eperr);
    endtask

    // Step until the clear sweep is over; returns the number of edges taken.
    task automatic wait_init(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!req_ready && n < 200);
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_wr_n   = 1'b1;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        err_inject = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_done", init_done, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, '0);

        // Clear sweep takes exactly DEPTH cycles after release
        rst_n = 1'b1;
        wait_init(n);
        chk("init_cycles", n, DEPTH);

        // Every word reads back zero (back-to-back reads)
        for (int a = 0; a < DEPTH; a++) begin
            req_valid = 1'b1; req_wr_n = 1'b1; req_addr = AW'(a);
            step();
        end
        req_valid = 1'b0;
        repeat (RDL + 1) step();

        // Byte-lane merge
        issue(1'b0, 4'd5, 32'hAABBCCDD, 4'hF, 1'b0);
        issue(1'b0, 4'd5, 32'h11223344, 4'h5, 1'b0);
        rd_expect(4'd5, 32'hAA22CC44, 1'b0, "merge");

        // Pipelined reads 1,2,3
        issue(1'b0, 4'd1, 32'h10, 4'hF, 1'b0);
        issue(1'b0, 4'd2, 32'h20, 4'hF, 1'b0);
        issue(1'b0, 4'd3, 32'h30, 4'hF, 1'b0);
        for (int a = 1; a <= 3; a++) begin
            req_valid = 1'b1; req_wr_n = 1'b1; req_addr = AW'(a);
            step();
        end
        req_valid = 1'b0;
        repeat (RDL + 1) step();

        // Write then immediate read; zero byte-enable is a no-op
        issue(1'b0, 4'd7, 32'h5A, 4'hF, 1'b0);
        rd_expect(4'd7, 32'h5A, 1'b0, "wr_rd");
        issue(1'b0, 4'd7, 32'hFFFFFFFF, 4'h0, 1'b0);
        rd_expect(4'd7, 32'h5A, 1'b0, "be_zero");

        // Parity injection
        issue(1'b0, 4'd3, 32'h0F, 4'hF, 1'b1);
`ifdef DMEM_PARITY_EN
        rd_expect(4'd3, 32'h0F, 1'b1, "par_inj");
`else
        rd_expect(4'd3, 32'h0F, 1'b0, "par_off");
`endif
        issue(1'b0, 4'd3, 32'h0F, 4'hF, 1'b0);
        rd_expect(4'd3, 32'h0F, 1'b0, "par_clean");

        // Reset one cycle after a read is accepted: response is dropped
        issue(1'b0, 4'd9, 32'h77, 4'hF, 1'b0);
        issue(1'b1, 4'd9, '0, '0, 1'b0);
        rst_n = 1'b0;
        step();
        chk("rst_drop_valid", rsp_valid, 1'b0);
        step();
        chk("rst_drop_valid2", rsp_valid, 1'b0);
        rst_n = 1'b1;
        wait_init(n);
        chk("reinit_cycles", n, DEPTH);
        rd_expect(4'd9, '0, 1'b0, "post_rst");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n      = ($urandom_range(0, 399) != 0);
            req_valid  = ($urandom_range(0, 3) != 0);
            req_wr_n   = 1'($urandom_range(0, 1));
            req_addr   = AW'($urandom_range(0, DEPTH - 1));
            req_wdata  = $urandom;
            req_be     = BEW'($urandom_range(0, 15));
            err_inject = ($urandom_range(0, 7) == 0);
            step();
        end
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        err_inject = 1'b0;
        repeat (RDL + 2) step();
        chk("drain_empty", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
